// File: rtl/bus_pkg.sv
// Shared types and constants for the memory/IO bus arbiter: FSM states,
// region decode and the IO address window.
package bus_pkg;

    localparam logic [1:0] IO_WINDOW = 2'b11;

    typedef enum logic {IDLE, OWN} bus_state_e;

    typedef enum logic {REG_RAM, REG_IO} bus_region_e;

    // Everything at or above the IO window aliases into IO space.
    function automatic bus_region_e decode_region(input logic [1:0] hi);
        return (hi == IO_WINDOW) ? REG_IO : REG_RAM;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational masked priority picker: first set bit of (req & mask),
// searching upward from start and wrapping, as one-hot plus index.
module bus_arb_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        gnt_oh = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!any && req[j] && mask[j]) begin
                any       = 1'b1;
                idx       = IDX_W'(j);
                gnt_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master byte bus arbiter with burst fairness, debug force and RAM/IO decode.
// Define BUS_RR_ARB_EN for round-robin instead of fixed-priority arbitration.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3,
    parameter int BURST_MAX      = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_MASTERS-1:0]           m_req,
    input  logic [NUM_MASTERS-1:0]           m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [NUM_MASTERS*8-1:0]         m_dout,
    input  logic [NUM_MASTERS-1:0]           m_force,
    output logic [NUM_MASTERS-1:0]           m_gnt,
    output logic [NUM_MASTERS-1:0]           m_rvalid,
    output logic [7:0]                       m_din,
    output logic [$clog2(NUM_MASTERS)-1:0]   owner,
    output logic                             ram_en,
    output logic                             ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0]        ram_a,
    output logic [7:0]                       ram_din,
    input  logic [7:0]                       ram_dout,
    output logic                             io_en,
    output logic                             io_wr,
    output logic [IO_SEL_WIDTH-1:0]          io_sel,
    output logic [7:0]                       io_din,
    input  logic [7:0]                       io_dout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(BURST_MAX - 1);

    bus_state_e              state, state_nxt;
    logic [IDX_W-1:0]        owner_nxt, arb_start, new_idx, f_idx, n_idx;
    logic [NUM_MASTERS-1:0]  gnt_nxt, f_oh, n_oh, rd_vld;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    f_any, n_any, take, others_wait;
    logic [ADDR_WIDTH-1:0]   own_a;
    logic [7:0]              own_d;
    logic                    own_wr, active;
    bus_region_e             region;
    logic [NUM_MASTERS-1:0]  vld_p1;
    logic                    src_io_p1;
    logic [7:0]              io_dout_p1;

`ifdef BUS_RR_ARB_EN
    logic [IDX_W-1:0] last_owner;

    assign arb_start = (last_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : last_owner + 1'b1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)    last_owner <= IDX_W'(NUM_MASTERS - 1);
        else if (take) last_owner <= new_idx;
    end
`else
    assign arb_start = '0;
`endif

    // Force only counts for a master that is actually requesting.
    bus_arb_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_force (
        .req(m_force), .mask(m_req), .start('0),
        .gnt_oh(f_oh), .idx(f_idx), .any(f_any)
    );

    // Normal search excludes the current owner so a rotation or release
    // always lands on somebody else.
    bus_arb_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_norm (
        .req(m_req), .mask(~m_gnt), .start(arb_start),
        .gnt_oh(n_oh), .idx(n_idx), .any(n_any)
    );

    assign others_wait = |(m_req & ~m_gnt);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        gnt_nxt   = m_gnt;
        cnt_nxt   = cnt;
        take      = 1'b0;
        new_idx   = '0;
        case (state)
            IDLE: begin
                if (|m_req) begin
                    take    = 1'b1;
                    new_idx = f_any ? f_idx : n_idx;
                end
            end
            OWN: begin
                if (f_any && f_idx != owner) begin
                    take    = 1'b1;
                    new_idx = f_idx;
                end else if (!m_req[owner]) begin
                    if (n_any) begin
                        take    = 1'b1;
                        new_idx = n_idx;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end else if (cnt == CNT_LIM && n_any && !f_any) begin
                    take    = 1'b1;
                    new_idx = n_idx;
                end else if (others_wait) begin
                    cnt_nxt = (cnt == CNT_LIM) ? cnt : cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            state_nxt = OWN;
            owner_nxt = new_idx;
            gnt_nxt   = NUM_MASTERS'(1) << new_idx;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            owner <= '0;
            m_gnt <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            m_gnt <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stage p0: combinational bus drive from the owner's slice.
    always_comb begin
        own_a   = m_a[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
        own_d   = m_dout[int'(owner)*8 +: 8];
        own_wr  = m_wr[owner];
        active  = (state == OWN) && m_req[owner];
        region  = decode_region(own_a[RAM_ADDR_WIDTH -: 2]);
        ram_en  = active && (region == REG_RAM);
        ram_wr  = active && (region == REG_RAM) && own_wr;
        io_en   = active && (region == REG_IO);
        io_wr   = active && (region == REG_IO) && own_wr;
        ram_a   = own_a[RAM_ADDR_WIDTH-1:0];
        io_sel  = own_a[IO_SEL_WIDTH-1:0];
        ram_din = own_d;
        io_din  = own_d;
        rd_vld  = (active && !own_wr) ? m_gnt : '0;
    end

    // Stage p1: read return; RAM data arrives now, IO data was captured at p0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) vld_p1 <= '0;
        else        vld_p1 <= rd_vld;
    end

    always_ff @(posedge clk_in) begin
        src_io_p1  <= (region == REG_IO);
        io_dout_p1 <= io_dout;
    end

    assign m_rvalid = vld_p1;
    assign m_din    = src_io_p1 ? io_dout_p1 : ram_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: two masters, fixed priority, BURST_MAX=4.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
    } txn_t;

    typedef struct {
        int         m;
        logic [7:0] d;
    } sb_t;

    logic        clk_in, rst_in;
    logic [1:0]  m_req, m_wr, m_force, m_gnt, m_rvalid;
    logic [63:0] m_a;
    logic [15:0] m_dout;
    logic [7:0]  m_din;
    logic [0:0]  owner;
    logic        ram_en, ram_wr, io_en, io_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_din, ram_dout, io_din, io_dout;
    logic [2:0]  io_sel;

    txn_t tq0[$];
    txn_t tq1[$];
    sb_t  sb[$];
    logic [1:0] perf;
    int n_chk, n_fail;

    mem_bus_arbiter #(.NUM_MASTERS(2), .BURST_MAX(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .m_req(m_req), .m_wr(m_wr),
        .m_a(m_a), .m_dout(m_dout), .m_force(m_force), .m_gnt(m_gnt),
        .m_rvalid(m_rvalid), .m_din(m_din), .owner(owner),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_din(ram_din),
        .ram_dout(ram_dout), .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel),
        .io_din(io_din), .io_dout(io_dout)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Environment: synchronous RAM returning addr+0x4A, IO registers returning 0xC0|sel.
    initial ram_dout = 8'h00;
    always @(posedge clk_in) if (ram_en && !ram_wr) ram_dout <= ram_a[7:0] + 8'h4A;
    assign io_dout = 8'hC0 | {5'b0, io_sel};

    function automatic logic [7:0] exp_rd(input logic [31:0] a);
        if (a[17:16] == 2'b11) return 8'hC0 | {5'b0, a[2:0]};
        return a[7:0] + 8'h4A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        m_req = {tq1.size() != 0, tq0.size() != 0};
        m_wr = 2'b00; m_a = '0; m_dout = '0;
        if (tq0.size() != 0) begin
            m_wr[0] = tq0[0].wr; m_a[31:0] = tq0[0].a; m_dout[7:0] = tq0[0].d;
        end
        if (tq1.size() != 0) begin
            m_wr[1] = tq1[0].wr; m_a[63:32] = tq1[0].a; m_dout[15:8] = tq1[0].d;
        end
    endtask

    // Advance one cycle; masters retire the access performed in the cycle just ended.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (perf[0] && tq0.size() != 0) tq0.delete(0);
        if (perf[1] && tq1.size() != 0) tq1.delete(0);
        drive_bus();
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((tq0.size() != 0 || tq1.size() != 0 || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain", (tq0.size() == 0 && tq1.size() == 0 && sb.size() == 0), 1);
        tick();
        tick();
    endtask

    // Monitor: score read returns, then record which accesses this cycle performs.
    always @(negedge clk_in) begin
        if (rst_in) begin
            perf = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_rvalid[i]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].m == i) idx = k;
                    if (idx >= 0) begin
                        chk("rdata", m_din, sb[idx].d);
                        sb.delete(idx);
                    end else begin
                        chk("rvalid_unexpected", 1, 0);
                    end
                end
            end
            perf = m_gnt & m_req;
            if (perf[0] && tq0.size() != 0 && !tq0[0].wr) sb.push_back('{0, exp_rd(tq0[0].a)});
            if (perf[1] && tq1.size() != 0 && !tq1[0].wr) sb.push_back('{1, exp_rd(tq1[0].a)});
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; perf = 2'b00;
        rst_in = 1'b1; m_req = '0; m_wr = '0; m_a = '0; m_dout = '0; m_force = '0;
        repeat (2) @(posedge clk_in);
        #2;
        chk("rst_gnt", m_gnt, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_io_en", io_en, 0);
        rst_in = 1'b0;

        // Single RAM read by master 0
        tq0.push_back('{1'b0, 32'h0000_0010, 8'h00});
        drive_bus();
        tick();
        chk("rd_gnt", m_gnt, 2'b01);
        chk("rd_ram_en", ram_en, 1);
        chk("rd_ram_a", ram_a, 17'h10);
        chk("rd_io_en", io_en, 0);
        tick();
        chk("rd_rvalid", m_rvalid, 2'b01);
        chk("rd_din", m_din, 8'h5A);
        tick();
        chk("rd_release", m_gnt, 0);

        // IO write by master 1
        tq1.push_back('{1'b1, 32'h0003_0004, 8'h41});
        drive_bus();
        tick();
        chk("wr_gnt", m_gnt, 2'b10);
        chk("wr_owner", owner, 1);
        chk("wr_io_en", io_en, 1);
        chk("wr_io_sel", io_sel, 4);
        chk("wr_io_wr", io_wr, 1);
        chk("wr_io_din", io_din, 8'h41);
        chk("wr_ram_en", ram_en, 0);
        tick();
        chk("wr_no_rvalid", m_rvalid, 0);
        tick();

        // IO read through an aliased address above the window
        tq1.push_back('{1'b0, 32'h0007_0002, 8'h00});
        drive_bus();
        tick();
        chk("ior_io_en", io_en, 1);
        chk("ior_io_sel", io_sel, 2);
        tick();
        chk("ior_rvalid", m_rvalid, 2'b10);
        chk("ior_din", m_din, 8'hC2);
        drain(10);

        // Both masters streaming: ownership rotates every 4 cycles
        for (int k = 0; k < 8; k++) begin
            tq0.push_back('{1'b0, 32'h100 + k, 8'h00});
            tq1.push_back('{1'b0, 32'h200 + k, 8'h00});
        end
        drive_bus();
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("burst_gnt", m_gnt, (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain(40);

        // Force preempts master 0 mid-burst; its last read still returns
        for (int k = 0; k < 6; k++) tq0.push_back('{1'b0, 32'h300 + k, 8'h00});
        for (int k = 0; k < 3; k++) tq1.push_back('{1'b0, 32'h0003_0005 + k, 8'h00});
        drive_bus();
        tick();
        chk("frc_pre_gnt", m_gnt, 2'b01);
        tick();
        m_force = 2'b10;
        tick();
        chk("frc_gnt", m_gnt, 2'b10);
        chk("frc_old_rvalid", m_rvalid, 2'b01);
        chk("frc_owner", owner, 1);
        for (int n = 0; n < 10 && tq1.size() != 0; n++) tick();
        m_force = 2'b00;
        drain(30);

        // Asynchronous reset during an IO read
        tq1.push_back('{1'b0, 32'h0003_0001, 8'h00});
        tq1.push_back('{1'b0, 32'h0003_0003, 8'h00});
        drive_bus();
        tick();
        chk("arst_pre_io_en", io_en, 1);
        #1 rst_in = 1'b1;
        #1;
        chk("arst_gnt", m_gnt, 0);
        chk("arst_io_en", io_en, 0);
        chk("arst_rvalid", m_rvalid, 0);
        tq1.delete();
        drive_bus();
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        tick();
        tick();
        chk("arst_hold_gnt", m_gnt, 0);
        chk("arst_hold_rvalid", m_rvalid, 0);
        chk("arst_hold_io_en", io_en, 0);

        // Recovery after reset
        tq0.push_back('{1'b0, 32'h0000_0055, 8'h00});
        drive_bus();
        tick();
        chk("rec_gnt", m_gnt, 2'b01);
        drain(10);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
